// File: rtl/rom_loader_receiver.sv
// rtl/rom_loader_receiver.sv - target side of the ROM loader handshake; streams loaded words into the instruction ROM
module rom_loader_receiver #(
    parameter int DATA_WIDTH  = 16,
    parameter int ADDR_WIDTH  = 15,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load_i,
    input  logic                  sck_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic                  ack_o,
    output logic                  rom_we,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    output logic [DATA_WIDTH-1:0] rom_wdata,
    input  logic                  rom_ready,
    output logic                  loading,
    output logic                  done,
    output logic [ADDR_WIDTH:0]   word_count,
    output logic                  overflow
);
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_ARMED = 3'd1;
    localparam logic [2:0] ST_WRITE = 3'd2;
    localparam logic [2:0] ST_ACK   = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = 1;
    localparam logic [ADDR_WIDTH:0]   COUNT_ONE = 1;

    logic [SYNC_STAGES-1:0] load_sync_q, load_sync_d;
    logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d;
    logic                   load_s, sck_s;

    logic [2:0]            state_q, state_d;
    logic                  ack_q, ack_d;
    logic                  rom_we_q, rom_we_d;
    logic [ADDR_WIDTH-1:0] rom_addr_q, rom_addr_d;
    logic [DATA_WIDTH-1:0] rom_wdata_q, rom_wdata_d;
    logic                  loading_q, loading_d;
    logic                  done_q, done_d;
    logic [ADDR_WIDTH:0]   word_count_q, word_count_d;
    logic                  overflow_q, overflow_d;

    assign load_s = load_sync_q[SYNC_STAGES-1];
    assign sck_s  = sck_sync_q[SYNC_STAGES-1];

    always_comb begin
        load_sync_d  = {load_sync_q[SYNC_STAGES-2:0], load_i};
        sck_sync_d   = {sck_sync_q[SYNC_STAGES-2:0], sck_i};
        state_d      = state_q;
        ack_d        = ack_q;
        rom_we_d     = rom_we_q;
        rom_addr_d   = rom_addr_q;
        rom_wdata_d  = rom_wdata_q;
        loading_d    = loading_q;
        done_d       = 1'b0;
        word_count_d = word_count_q;
        overflow_d   = overflow_q;
        case (state_q)
            ST_IDLE: begin
                if (load_s) begin
                    rom_addr_d   = '0;
                    word_count_d = '0;
                    overflow_d   = 1'b0;
                    loading_d    = 1'b1;
                    state_d      = ST_ARMED;
                end
            end
            ST_ARMED: begin
                // A pending strobe wins over session end so no word is dropped
                if (sck_s) begin
                    rom_wdata_d = data_i;
                    if (!word_count_q[ADDR_WIDTH]) begin
                        rom_we_d = 1'b1;
                        state_d  = ST_WRITE;
                    end else begin
                        overflow_d = 1'b1;
                        ack_d      = 1'b1;
                        state_d    = ST_ACK;
                    end
                end else if (!load_s) begin
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_WRITE: begin
                if (rom_ready) begin
                    rom_we_d     = 1'b0;
                    rom_addr_d   = rom_addr_q + ADDR_ONE;
                    word_count_d = word_count_q + COUNT_ONE;
                    ack_d        = 1'b1;
                    state_d      = ST_ACK;
                end
            end
            ST_ACK: begin
                if (!sck_s) begin
                    ack_d = 1'b0;
                    if (!load_s) begin
                        done_d  = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_ARMED;
                    end
                end
            end
            ST_DONE: begin
                loading_d = 1'b0;
                state_d   = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            load_sync_q  <= '0;
            sck_sync_q   <= '0;
            state_q      <= ST_IDLE;
            ack_q        <= 1'b0;
            rom_we_q     <= 1'b0;
            rom_addr_q   <= '0;
            rom_wdata_q  <= '0;
            loading_q    <= 1'b0;
            done_q       <= 1'b0;
            word_count_q <= '0;
            overflow_q   <= 1'b0;
        end else begin
            load_sync_q  <= load_sync_d;
            sck_sync_q   <= sck_sync_d;
            state_q      <= state_d;
            ack_q        <= ack_d;
            rom_we_q     <= rom_we_d;
            rom_addr_q   <= rom_addr_d;
            rom_wdata_q  <= rom_wdata_d;
            loading_q    <= loading_d;
            done_q       <= done_d;
            word_count_q <= word_count_d;
            overflow_q   <= overflow_d;
        end
    end

    assign ack_o      = ack_q;
    assign rom_we     = rom_we_q;
    assign rom_addr   = rom_addr_q;
    assign rom_wdata  = rom_wdata_q;
    assign loading    = loading_q;
    assign done       = done_q;
    assign word_count = word_count_q;
    assign overflow   = overflow_q;
endmodule
